// File: rtl/bp_jmp_ctrl.sv
// bp_jmp_ctrl: direct-mapped BTB predictor with redirect, squash window and saturating perf counters
module bp_jmp_ctrl #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W = 8,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [XLEN-1:0]   f_pc,
  output logic              f_pred_taken,
  output logic [XLEN-1:0]   f_pred_target,
  input  logic              r_valid,
  input  logic [1:0]        r_kind,
  input  logic [XLEN-1:0]   r_pc,
  input  logic              r_taken,
  input  logic [XLEN-1:0]   r_target,
  input  logic              r_pred_taken,
  input  logic [XLEN-1:0]   r_pred_target,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PERF_W-1:0] mispredict_cnt,
  output logic [PERF_W-1:0] branch_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  logic [ENTRIES-1:0] r_vld, r_jmp;
  logic [TAG_W-1:0] r_tag [ENTRIES];
  logic [XLEN-1:0] r_tgt [ENTRIES];
  logic [1:0] r_ctr [ENTRIES];
  logic [1:0] r_shadow;
  logic [PERF_W-1:0] r_mis_cnt, r_br_cnt;
  logic [IDX_W-1:0] w_fi, w_ri;
  logic [TAG_W-1:0] w_rtag;
  logic [1:0] w_ctr_nx;
  logic w_fhit, w_rhit, w_squash, w_act, w_qual, w_mis, w_unused;
  always_comb begin
    w_fi = f_pc[IDX_W+1:2];
    w_ri = r_pc[IDX_W+1:2];
    w_rtag = r_pc[IDX_W+2 +: TAG_W];
    w_fhit = r_vld[w_fi] && r_tag[w_fi] == f_pc[IDX_W+2 +: TAG_W];
    w_rhit = r_vld[w_ri] && r_tag[w_ri] == w_rtag;
    f_pred_taken = w_fhit && (r_jmp[w_fi] || r_ctr[w_fi][1]);
    f_pred_target = w_fhit ? r_tgt[w_fi] : '0;
    w_squash = r_shadow != 2'd0;
    w_act = r_kind != 2'b00 || r_taken;
    w_qual = r_valid && ena && !reset && !w_squash && r_kind != 2'b11;
    w_mis = w_qual && (w_act != r_pred_taken || (w_act && r_pred_target != r_target));
    redirect = w_mis;
    redirect_pc = w_mis ? (w_act ? r_target : r_pc + XLEN'(4)) : '0;
    w_ctr_nx = w_act ? (&r_ctr[w_ri] ? 2'b11 : r_ctr[w_ri] + 2'd1)
                     : (r_ctr[w_ri] == 2'b00 ? 2'b00 : r_ctr[w_ri] - 2'd1);
    mispredict_cnt = r_mis_cnt;
    branch_cnt = r_br_cnt;
    w_unused = ^{f_pc, r_pc};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_jmp <= '0;
      r_shadow <= 2'd0;
      r_mis_cnt <= '0;
      r_br_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CNT_INIT;
    end else begin
      if (ena) r_shadow <= w_mis ? 2'd2 : (w_squash ? r_shadow - 2'd1 : r_shadow);
      if (w_qual) begin
        if (w_rhit) begin
          r_ctr[w_ri] <= w_ctr_nx;
          r_jmp[w_ri] <= r_kind != 2'b00;
          if (w_act) r_tgt[w_ri] <= r_target;
        end else if (w_act) begin
          r_vld[w_ri] <= 1'b1;
          r_tag[w_ri] <= w_rtag;
          r_tgt[w_ri] <= r_target;
          r_ctr[w_ri] <= r_kind == 2'b00 ? CNT_INIT : 2'b11;
          r_jmp[w_ri] <= r_kind != 2'b00;
        end
        r_br_cnt <= &r_br_cnt ? r_br_cnt : r_br_cnt + PERF_W'(1);
        if (w_mis) r_mis_cnt <= &r_mis_cnt ? r_mis_cnt : r_mis_cnt + PERF_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_bp_jmp_ctrl.sv
// tb_bp_jmp_ctrl: vector table, directed squash/saturation/reset sequences and random model check
module tb_bp_jmp_ctrl;
  localparam int ENTRIES = 16;
  localparam int TAG_W = 8;
  localparam int PERF_W = 4;
  localparam int PMAX = 15;
  logic clk = 1'b0;
  logic reset, ena, f_pred_taken, r_valid, r_taken, r_pred_taken, redirect;
  logic [31:0] f_pc, f_pred_target, r_pc, r_target, r_pred_target, redirect_pc;
  logic [1:0] r_kind;
  logic [PERF_W-1:0] mispredict_cnt, branch_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bp_jmp_ctrl #(.XLEN(32), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_INIT(2'b01), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset), .ena(ena), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .f_pred_target(f_pred_target), .r_valid(r_valid), .r_kind(r_kind), .r_pc(r_pc),
    .r_taken(r_taken), .r_target(r_target), .r_pred_taken(r_pred_taken),
    .r_pred_target(r_pred_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt), .branch_cnt(branch_cnt)
  );
  typedef struct {
    logic rs, en, v;
    logic [1:0] k;
    logic [31:0] pc;
    logic tk;
    logic [31:0] tg;
    logic ptk;
    logic [31:0] ptg, fpc;
    logic e_red;
    logic [31:0] e_rpc;
    logic e_fpt;
    logic [31:0] e_fpa;
    int e_mis, e_br;
  } vec_t;
  typedef struct {
    bit v;
    logic [TAG_W-1:0] tag;
    logic [31:0] tgt;
    int ctr;
    bit jmp;
  } ent_t;
  vec_t tbl[$];
  ent_t m [ENTRIES];
  int m_sh, m_mis, m_br;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  task automatic drive(logic rs, logic en, logic v, logic [1:0] k, logic [31:0] pc, logic tk,
                       logic [31:0] tg, logic ptk, logic [31:0] ptg, logic [31:0] fpc);
    reset = rs; ena = en; r_valid = v; r_kind = k; r_pc = pc; r_taken = tk;
    r_target = tg; r_pred_taken = ptk; r_pred_target = ptg; f_pc = fpc;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(logic [31:0] fpc);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, fpc);
  endtask
  task automatic mp(logic rs, logic en);
    drive(rs, en, 1'b1, 2'b01, 32'h400, 1'b0, 32'h800, 1'b0, 32'h0, 32'h400);
  endtask
  function automatic vec_t mk(logic rs, logic en, logic v, logic [1:0] k, logic [31:0] pc, logic tk,
                              logic [31:0] tg, logic ptk, logic [31:0] ptg, logic [31:0] fpc,
                              logic red, logic [31:0] rpc, logic fpt, logic [31:0] fpa, int mis, int br);
    vec_t x;
    x = '{rs, en, v, k, pc, tk, tg, ptk, ptg, fpc, red, rpc, fpt, fpa, mis, br};
    return x;
  endfunction
  function automatic vec_t mi(logic [31:0] fpc, logic fpt, logic [31:0] fpa, int mis, int br);
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, fpc, 0, 0, fpt, fpa, mis, br);
  endfunction
  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(logic [31:0] pc);
    return TAG_W'((pc >> (2 + $clog2(ENTRIES))) % (1 << TAG_W));
  endfunction
  function automatic void mlook(input logic [31:0] pc, output logic t, output logic [31:0] a);
    int i;
    logic h;
    i = idx_of(pc);
    h = m[i].v && m[i].tag == tag_of(pc);
    t = h && (m[i].jmp || m[i].ctr >= 2);
    a = h ? m[i].tgt : 32'h0;
  endfunction
  function automatic logic [31:0] rpool();
    if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFC;
    return 32'(($urandom_range(0, 1) << 14) | ($urandom_range(0, 3) << 6) |
               ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
  endfunction
  initial begin
    tbl.push_back(mk(1,1,1,0,'h100,1,'h80,0,0,'h100, 0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,0,'h100,1,'h80,0,0,'h100, 1,'h80,0,0, 1,1));
    tbl.push_back(mk(0,1,1,0,'h100,1,'h80,0,0,'h100, 0,0,0,'h80, 1,1));
    tbl.push_back(mk(0,1,1,0,'h100,1,'h80,0,0,'h100, 0,0,0,'h80, 1,1));
    tbl.push_back(mk(0,1,1,0,'h100,1,'h80,0,0,'h100, 1,'h80,0,'h80, 2,2));
    tbl.push_back(mi('h100, 1,'h80, 2,2));
    tbl.push_back(mi('h100, 1,'h80, 2,2));
    tbl.push_back(mk(0,1,1,0,'h100,1,'h80,1,'h80,'h100, 0,0,1,'h80, 2,3));
    tbl.push_back(mk(0,1,1,0,'h100,0,'h80,1,'h80,'h100, 1,'h104,1,'h80, 3,4));
    tbl.push_back(mk(0,1,1,0,'h100,1,'h80,0,0,'h100, 0,0,1,'h80, 3,4));
    tbl.push_back(mk(0,1,1,0,'h100,1,'h80,0,0,'h100, 0,0,1,'h80, 3,4));
    tbl.push_back(mk(0,1,1,0,'h100,0,'h80,0,0,'h100, 0,0,1,'h80, 3,5));
    tbl.push_back(mi('h100, 0,'h80, 3,5));
    tbl.push_back(mk(0,1,1,2,'h200,0,'h340,1,'h300,'h200, 1,'h340,0,0, 4,6));
    tbl.push_back(mi('h200, 1,'h340, 4,6));
    tbl.push_back(mi('h100, 0,0, 4,6));
    tbl.push_back(mk(0,1,1,2,'h200,0,'h380,1,'h340,'h200, 1,'h380,1,'h340, 5,7));
    tbl.push_back(mi('h200, 1,'h380, 5,7));
    tbl.push_back(mi('h140, 0,0, 5,7));
    tbl.push_back(mk(0,1,1,0,'h140,1,'h40,0,0,'h200, 1,'h40,1,'h380, 6,8));
    tbl.push_back(mi('h200, 0,0, 6,8));
    tbl.push_back(mi('h140, 0,'h40, 6,8));
    tbl.push_back(mk(0,0,1,1,'h300,0,'h500,0,0,'h140, 0,0,0,'h40, 6,8));
    tbl.push_back(mk(0,1,1,3,'h300,1,'h500,0,0,'h140, 0,0,0,'h40, 6,8));
    tbl.push_back(mk(0,1,1,1,'h300,0,'h500,1,'h500,'h300, 0,0,0,0, 6,9));
    tbl.push_back(mi('h300, 1,'h500, 6,9));
    tbl.push_back(mk(0,1,1,0,'h104,0,0,0,0,'h300, 0,0,1,'h500, 6,10));
    tbl.push_back(mi('h104, 0,0, 6,10));
    tbl.push_back(mk(0,1,1,0,'h300,1,'h600,1,'h500,'h300, 1,'h600,1,'h500, 7,11));
    tbl.push_back(mi('h300, 1,'h600, 7,11));
    tbl.push_back(mi('h300, 1,'h600, 7,11));
    drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    tick;
    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].en, tbl[i].v, tbl[i].k, tbl[i].pc, tbl[i].tk, tbl[i].tg,
            tbl[i].ptk, tbl[i].ptg, tbl[i].fpc);
      chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(tbl[i].e_red));
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc, tbl[i].e_rpc);
      chk($sformatf("v%0d_pred_taken", i), 32'(f_pred_taken), 32'(tbl[i].e_fpt));
      chk($sformatf("v%0d_pred_target", i), f_pred_target, tbl[i].e_fpa);
      tick;
      chk($sformatf("v%0d_mis_cnt", i), 32'(mispredict_cnt), tbl[i].e_mis);
      chk($sformatf("v%0d_br_cnt", i), 32'(branch_cnt), tbl[i].e_br);
    end
    mp(1'b0, 1'b1);
    chk("sq_first", 32'(redirect), 1);
    tick;
    for (int i = 0; i < 3; i++) begin
      mp(1'b0, 1'b0);
      chk("sq_ena0", 32'(redirect), 0);
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      mp(1'b0, 1'b1);
      chk("sq_window", 32'(redirect), 0);
      tick;
    end
    mp(1'b0, 1'b1);
    chk("sq_after", 32'(redirect), 1);
    tick;
    chk("sq_mis_cnt", 32'(mispredict_cnt), 9);
    chk("sq_br_cnt", 32'(branch_cnt), 13);
    for (int i = 0; i < 20; i++) begin
      idle(32'h0);
      tick;
      idle(32'h0);
      tick;
      mp(1'b0, 1'b1);
      chk("sat_redirect", 32'(redirect), 1);
      tick;
    end
    chk("sat_mis_cnt", 32'(mispredict_cnt), PMAX);
    chk("sat_br_cnt", 32'(branch_cnt), PMAX);
    mp(1'b0, 1'b1);
    chk("rs_pre", 32'(redirect), 0);
    idle(32'h0);
    tick;
    tick;
    mp(1'b0, 1'b1);
    chk("rs_open", 32'(redirect), 1);
    tick;
    mp(1'b1, 1'b1);
    chk("rs_redirect", 32'(redirect), 0);
    chk("rs_redirect_pc", redirect_pc, 0);
    tick;
    chk("rs_mis_cnt", 32'(mispredict_cnt), 0);
    chk("rs_br_cnt", 32'(branch_cnt), 0);
    mp(1'b0, 1'b1);
    chk("rs_pred_taken", 32'(f_pred_taken), 0);
    chk("rs_squash_cleared", 32'(redirect), 1);
    chk("rs_squash_pc", redirect_pc, 32'h800);
    tick;
    chk("rs_mis_one", 32'(mispredict_cnt), 1);
    chk("rs_br_one", 32'(branch_cnt), 1);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick;
    foreach (m[i]) m[i] = '{1'b0, '0, 32'h0, 1, 1'b0};
    m_sh = 0;
    m_mis = 0;
    m_br = 0;
    for (int n = 0; n < 3000; n++) begin
      logic rs, en, v, tk, ptk, et, act, qual, mis;
      logic [1:0] k;
      logic [31:0] pc, tg, ptg, fpc, ea, erpc;
      int i;
      rs = $urandom_range(0, 199) == 0;
      en = $urandom_range(0, 9) != 0;
      v = $urandom_range(0, 3) != 0;
      k = 2'($urandom_range(0, 3));
      tk = $urandom_range(0, 1) == 1;
      pc = rpool();
      fpc = $urandom_range(0, 3) == 0 ? pc : rpool();
      tg = 32'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 1) == 1) mlook(pc, ptk, ptg);
      else begin
        ptk = $urandom_range(0, 1) == 1;
        ptg = $urandom_range(0, 1) == 1 ? tg : 32'($urandom_range(0, 255) << 2);
      end
      drive(rs, en, v, k, pc, tk, tg, ptk, ptg, fpc);
      mlook(fpc, et, ea);
      act = k != 2'd0 || tk;
      qual = v && en && !rs && m_sh == 0 && k != 2'd3;
      mis = qual && (act != ptk || (act && ptg != tg));
      erpc = mis ? (act ? tg : pc + 32'd4) : 32'h0;
      chk("rnd_pred_taken", 32'(f_pred_taken), 32'(et));
      chk("rnd_pred_target", f_pred_target, ea);
      chk("rnd_redirect", 32'(redirect), 32'(mis));
      chk("rnd_redirect_pc", redirect_pc, erpc);
      tick;
      if (rs) begin
        foreach (m[j]) m[j].v = 1'b0;
        m_sh = 0;
        m_mis = 0;
        m_br = 0;
      end else if (en) begin
        if (qual) begin
          i = idx_of(pc);
          if (m[i].v && m[i].tag == tag_of(pc)) begin
            m[i].ctr = act ? (m[i].ctr < 3 ? m[i].ctr + 1 : 3) : (m[i].ctr > 0 ? m[i].ctr - 1 : 0);
            if (act) m[i].tgt = tg;
            m[i].jmp = k != 2'd0;
          end else if (act) m[i] = '{1'b1, tag_of(pc), tg, (k == 2'd0) ? 1 : 3, k != 2'd0};
          m_br = m_br < PMAX ? m_br + 1 : PMAX;
          if (mis) m_mis = m_mis < PMAX ? m_mis + 1 : PMAX;
        end
        m_sh = mis ? 2 : (m_sh > 0 ? m_sh - 1 : 0);
      end
      chk("rnd_mis_cnt", 32'(mispredict_cnt), m_mis);
      chk("rnd_br_cnt", 32'(branch_cnt), m_br);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_jmp_ctrl.md
Name: bp_jmp_ctrl

Overview:
- Parametrised successor to the single-bit-prediction jump controller.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. The fetch stage queries it with the current PC. Branch/jump resolution in the ALU stage updates it and drives the PC-redirect path.
- Adds JAL/JALR target prediction, mispredict-on-wrong-target detection, a flush-suppression window and saturating performance counters.
- Sits between the fetch PC mux and the execute stage.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 16, BTB entries; power of two, 2..256. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits taken from pc[IDX_W+2 +: TAG_W].
- CNT_INIT, 2'b01, counter value on allocation (weakly not-taken).
- PERF_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- ena  in  1  pipeline advance; when 0, no table/counter updates and redirect=0.
- f_pc  in  XLEN  fetch-stage PC.
- f_pred_taken  out  1  prediction for f_pc; combinational.
- f_pred_target  out  XLEN  predicted target; valid when f_pred_taken=1.
- r_valid  in  1  resolve slot holds a control-flow instruction.
- r_kind  in  2  00 cond branch, 01 jal, 10 jalr, 11 reserved (treated as no-op).
- r_pc  in  XLEN  PC of the resolving instruction.
- r_taken  in  1  actual outcome; ignored for jal/jalr, which are always taken.
- r_target  in  XLEN  actual target; the jalr target arrives with bit0 already cleared.
- r_pred_taken  in  1  prediction carried down the pipe.
- r_pred_target  in  XLEN  predicted target carried down the pipe.
- redirect  out  1  PC write request to fetch.
- redirect_pc  out  XLEN  corrected PC.
- mispredict_cnt  out  PERF_W  saturating count of redirects.
- branch_cnt  out  PERF_W  saturating count of resolved r_kind 00/01/10.

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[XLEN], ctr[2], is_jmp.
- Index = pc[IDX_W+1:2]; pc[1:0] are ignored.
- Lookup, combinational from f_pc:
  - hit = valid && tag match.
  - f_pred_taken = hit && (is_jmp || ctr[1]).
  - f_pred_target = entry target; 0 when no hit.
- Resolve, combinational from the r_* inputs:
  - act_taken = (r_kind!=00) || r_taken.
  - mis = r_valid && ena && !reset && !squash && r_kind!=11 && (act_taken!=r_pred_taken || (act_taken && r_pred_target!=r_target)).
  - redirect = mis.
  - redirect_pc = act_taken ? r_target : r_pc+4 (modulo 2^XLEN); 0 when redirect=0.
- Update, at the rising edge when r_valid && ena && r_kind!=11 && !squash:
  - Entry hit: ctr moves +1 if act_taken, else -1, saturating at 00/11. Target is overwritten when act_taken. is_jmp is set to (r_kind!=00).
  - Entry missed and act_taken: allocate. valid=1, tag and target written. ctr = CNT_INIT for a branch, 2'b11 for a jump.
  - Entry missed and not taken: no allocation.
- Lookup/update collision (same index, same cycle): lookup returns the pre-update contents; the new contents are visible next cycle.
- Squash:
  - A 2-bit shadow counter is loaded with 2 on redirect. It decrements each ena cycle.
  - squash = (shadow!=0). While squash=1, r_valid is ignored (wrong-path instructions in flight).
  - A redirect cannot occur while squash=1.
- Performance counters:
  - Both increment on the same qualified resolve event as an update.
  - mispredict_cnt also requires mis.
  - Both saturate at all-ones; no wrap.
- Reset, synchronous:
  - All valid=0, ctr=CNT_INIT, shadow=0, both counters=0.
  - Outputs that cycle: redirect=0, redirect_pc=0. f_pred_taken=0 from the next cycle.
  - A reset asserted during the squash window clears it immediately.
- ena=0: all state frozen, redirect=0. Lookup outputs stay live.

Test Plan:
- Reset, then f_pc=0x100 -> f_pred_taken=0, f_pred_target=0. All counters 0.
- Branch at 0x100, taken to 0x80, r_pred_taken=0 -> redirect=1, redirect_pc=0x80. Next cycle the 0x100 lookup gives ctr=01, f_pred_taken=0. After a second taken resolve (ctr=10) -> f_pred_taken=1, f_pred_target=0x80.
- Same branch resolves not-taken with r_pred_taken=1 -> redirect_pc=0x104, ctr 11->10. The following two ena cycles with r_valid=1 produce no redirect and no counter change.
- jalr at 0x200, predicted target 0x300, actual 0x340 -> redirect=1, redirect_pc=0x340. Entry target becomes 0x340 and is_jmp=1.
- Aliasing with ENTRIES=16: 0x100 and 0x140 share an index; resolving 0x140 taken evicts the tag -> lookup of 0x100 misses.
- Saturation: PERF_W=4, 20 mispredicts spaced beyond the squash window -> mispredict_cnt=15, branch_cnt=15. ena=0 during a resolve -> no change.
